// File: rtl/crc32_pkg.sv
// CRC-32 (IEEE 802.3) constants and the parallel 8-bit step shared by the FCS path.
// Exports CRC_POLY_REFL, CRC_INIT, CRC_XOROUT, CRC_RESIDUE, crc8_step, crc8_step_p.
package crc32_pkg;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_XOROUT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

   // LSB-first byte step with an explicit polynomial; the loop unrolls to XOR trees.
   function automatic logic [31:0] crc8_step_p(
      input logic [31:0] c,
      input logic [7:0]  d,
      input logic [31:0] poly
   );
      logic [31:0] x;
      x = c;
      for (int i = 0; i < 8; i++) begin
         x = (x >> 1) ^ ((x[0] ^ d[i]) ? poly : 32'h0);
      end
      return x;
   endfunction

   function automatic logic [31:0] crc8_step(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      return crc8_step_p(c, d, CRC_POLY_REFL);
   endfunction

endpackage

// File: rtl/crc32_comb.sv
// Ethernet FCS generator: absorbs one TX byte per eth_tx_clk, presents the FCS in wire order.
// Ports: eth_tx_clk, rst (sync, active-low), updatecrc, crc_lsb, data[7:0] in; result[31:0] out.
module crc32_comb
   import crc32_pkg::*;
#(
   parameter logic [31:0] POLY_REFL  = CRC_POLY_REFL,
   parameter logic [31:0] CRC_INIT_V = CRC_INIT,
   parameter logic [31:0] XOROUT     = CRC_XOROUT
) (
   input  logic        eth_tx_clk,
   input  logic        rst,
   input  logic        updatecrc,
   input  logic        crc_lsb,
   input  logic [7:0]  data,
   output logic [31:0] result
);

   logic [31:0] crc_reg;
   logic [31:0] crc_next;
   logic [31:0] fcs;
   logic        frozen;

   assign crc_next = crc8_step_p(crc_reg, data, POLY_REFL);

   // crc_lsb freezes the register so the framer can loop FCS bytes back on data.
   always_ff @(posedge eth_tx_clk) begin
      if (!rst) begin
         crc_reg <= CRC_INIT_V;
         frozen  <= 1'b0;
      end else if (crc_lsb) begin
         frozen  <= 1'b1;
      end else if (updatecrc && !frozen) begin
         crc_reg <= crc_next;
      end
   end

   // Byte swap so result[31:24] is the first FCS byte on the wire.
   assign fcs    = crc_reg ^ XOROUT;
   assign result = {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]};

endmodule

// File: tb/tb_crc32_comb.sv
// Directed and random-frame checks of the byte-wide Ethernet FCS generator.
// Drives inputs 1ns after each rising edge and samples result there.
module tb_crc32_comb;

   logic        eth_tx_clk;
   logic        rst;
   logic        updatecrc;
   logic        crc_lsb;
   logic [7:0]  data;
   logic [31:0] result;

   int n_vec;
   int n_bad;

   crc32_comb dut (
      .eth_tx_clk (eth_tx_clk),
      .rst        (rst),
      .updatecrc  (updatecrc),
      .crc_lsb    (crc_lsb),
      .data       (data),
      .result     (result)
   );

   initial eth_tx_clk = 1'b0;
   always #5 eth_tx_clk = ~eth_tx_clk;

   task automatic tick();
      @(posedge eth_tx_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; updatecrc = 1'b0; crc_lsb = 1'b0; data = 8'h00;
      tick();
      rst = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      updatecrc = 1'b1; crc_lsb = 1'b0; data = b;
      tick();
      updatecrc = 1'b0;
   endtask

   task automatic send_check_str();
      for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
   endtask

   // Independent model: non-reflected MSB-first shift with bit-reversed output.
   function automatic logic [31:0] model_result(input logic [7:0] q[$]);
      logic [31:0] c;
      logic [31:0] r;
      logic [31:0] f;
      logic        fb;
      c = 32'hFFFF_FFFF;
      foreach (q[k]) begin
         for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ q[k][i];
            c  = (c << 1) ^ (fb ? 32'h04C1_1DB7 : 32'h0);
         end
      end
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
      f = ~r;
      return {f[7:0], f[15:8], f[23:16], f[31:24]};
   endfunction

   task automatic test_reset();
      rst = 1'b0; updatecrc = 1'b0; crc_lsb = 1'b0; data = 8'h00;
      tick(); tick();
      rst = 1'b1;
      tick();
      n_vec++;
      if (result !== 32'h0000_0000) begin
         n_bad++;
         $display("FAIL reset: got %h want %h", result, 32'h0);
      end
   endtask

   task automatic test_single_zero();
      do_reset();
      send_byte(8'h00);
      n_vec++;
      if (result !== 32'h8DEF_02D2) begin
         n_bad++;
         $display("FAIL single_zero: got %h want %h", result, 32'h8DEF02D2);
      end
      tick();
      n_vec++;
      if (result !== 32'h8DEF_02D2) begin
         n_bad++;
         $display("FAIL idle_hold: got %h want %h", result, 32'h8DEF02D2);
      end
   endtask

   task automatic test_check_string();
      do_reset();
      send_check_str();
      n_vec++;
      if (result !== 32'h2639_F4CB) begin
         n_bad++;
         $display("FAIL check_str: got %h want %h", result, 32'h2639F4CB);
      end
   endtask

   task automatic test_freeze_loopback();
      logic [31:0] fcs_w;
      do_reset();
      send_check_str();
      updatecrc = 1'b1; crc_lsb = 1'b1; data = 8'hAA;
      tick();
      n_vec++;
      if (result !== 32'h2639_F4CB) begin
         n_bad++;
         $display("FAIL both_high: got %h want %h", result, 32'h2639F4CB);
      end
      crc_lsb = 1'b0;
      fcs_w = 32'h2639_F4CB;
      for (int i = 0; i < 4; i++) begin
         updatecrc = 1'b1;
         data = fcs_w[31-8*i -: 8];
         tick();
         n_vec++;
         if (result !== 32'h2639_F4CB) begin
            n_bad++;
            $display("FAIL loopback%0d: got %h want %h", i, result, 32'h2639F4CB);
         end
      end
      updatecrc = 1'b0;
      do_reset();
      send_byte(8'h00);
      n_vec++;
      if (result !== 32'h8DEF_02D2) begin
         n_bad++;
         $display("FAIL unfreeze: got %h want %h", result, 32'h8DEF02D2);
      end
   endtask

   task automatic test_residue();
      do_reset();
      send_check_str();
      send_byte(8'h26);
      send_byte(8'h39);
      send_byte(8'hF4);
      send_byte(8'hCB);
      // crc_reg 0xDEBB20E3 complemented and byte-swapped.
      n_vec++;
      if (result !== 32'h1CDF_4421) begin
         n_bad++;
         $display("FAIL residue: got %h want %h", result, 32'h1CDF4421);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
      rst = 1'b0; updatecrc = 1'b1; data = 8'h55;
      tick();
      rst = 1'b1; updatecrc = 1'b0;
      n_vec++;
      if (result !== 32'h0000_0000) begin
         n_bad++;
         $display("FAIL mid_reset: got %h want %h", result, 32'h0);
      end
      send_check_str();
      n_vec++;
      if (result !== 32'h2639_F4CB) begin
         n_bad++;
         $display("FAIL after_reset: got %h want %h", result, 32'h2639F4CB);
      end
   endtask

   task automatic test_random_frames();
      logic [7:0]  q[$];
      logic [31:0] exp;
      int          len;
      for (int f = 0; f < 4; f++) begin
         q.delete();
         len = (f == 0) ? 60 : (f == 1) ? 1514 : int'($urandom_range(60, 1514));
         for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
         exp = model_result(q);
         do_reset();
         foreach (q[k]) begin
            updatecrc = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            if (!updatecrc) begin
               data = 8'($urandom_range(0, 255));
               tick();
            end
            send_byte(q[k]);
         end
         crc_lsb = 1'b1;
         tick();
         crc_lsb = 1'b0;
         n_vec++;
         if (result !== exp) begin
            n_bad++;
            $display("FAIL frame%0d len %0d: got %h want %h", f, len, result, exp);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b0; updatecrc = 1'b0; crc_lsb = 1'b0; data = 8'h00;
      test_reset();
      test_single_zero();
      test_check_string();
      test_freeze_loopback();
      test_residue();
      test_mid_reset();
      test_random_frames();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
